mmio_mem_controller: RTL

Parametrised address decoder and sequencer for the ASIP data port. It maps a request address onto three regions: image ROM, data RAM, and a switch MMIO window. It replaces the purely combinational decoder with a registered request/response handshake, configurable memory latency, synchronised and debounced switch inputs, and an error response for illegal accesses.

---
 rtl/mmio_mem_if.sv | 28 ++
 rtl/mmio_mem_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_mem_if.sv
// Request/response channel of the ASIP data port, shared by the controller and its master.
// A request transfers on a rising edge where req_valid && req_ready; the master holds we/vf/addr/wd
// stable while req_valid=1 and req_ready=0. rsp_valid is a one-cycle pulse with no back-pressure,
// and rd/rsp_err are meaningful only while it is high.
interface mmio_mem_if #(
   parameter int ADDR_W = 128,
   parameter int DATA_W = 128
);
   logic              req_valid;
   logic              req_ready;
   logic              we;
   logic              vf;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wd;
   logic              rsp_valid;
   logic [DATA_W-1:0] rd;
   logic              rsp_err;

   modport master (
      output req_valid, we, vf, addr, wd,
      input  req_ready, rsp_valid, rd, rsp_err
   );

   modport slave (
      input  req_valid, we, vf, addr, wd,
      output req_ready, rsp_valid, rd, rsp_err
   );
endinterface

// File: rtl/mmio_mem_controller.sv
// ASIP data-port decoder/sequencer: image ROM, data RAM and a debounced switch MMIO window behind
// a registered request/response handshake. Optional macro SW_EDGE_EN adds sticky rising-edge flags.
module mmio_mem_controller #(
   parameter int ADDR_W     = 128,
   parameter int DATA_W     = 128,
   parameter int ROM_BASE   = 0,
   parameter int ROM_SIZE   = 120000,
   parameter int RAM_BASE   = 120000,
   parameter int RAM_SIZE   = 121000,
   parameter int SW_BASE    = 241000,
   parameter int N_SW       = 21,
   parameter int MEM_LAT    = 1,
   parameter int DEB_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   mmio_mem_if.slave         bus,
   input  logic [N_SW-1:0]   sw_in,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_rd,
   output logic              ram_we,
   output logic              ram_vf,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wd,
   input  logic [DATA_W-1:0] ram_rd,
   output logic [1:0]        dbg_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, MEM_WAIT = 2'd1, RESP = 2'd2} state_t;
   typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_SW, REG_NONE} region_t;

`ifdef SW_EDGE_EN
   localparam int SW_SPAN = 2 * N_SW;
`else
   localparam int SW_SPAN = N_SW;
`endif
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [ADDR_W-1:0] ROM_LO = ADDR_W'(ROM_BASE);
   localparam logic [ADDR_W-1:0] ROM_SZ = ADDR_W'(ROM_SIZE);
   localparam logic [ADDR_W-1:0] RAM_LO = ADDR_W'(RAM_BASE);
   localparam logic [ADDR_W-1:0] RAM_SZ = ADDR_W'(RAM_SIZE);
   localparam logic [ADDR_W-1:0] SW_LO  = ADDR_W'(SW_BASE);
   localparam logic [ADDR_W-1:0] SW_SZ  = ADDR_W'(SW_SPAN);

   state_t            state_q;
   logic              ready_q, rsp_valid_q, rsp_err_q, rom_sel_q;
   logic              ram_we_q, ram_vf_q;
   logic [DATA_W-1:0] rd_q, ram_wd_q;
   logic [ADDR_W-1:0] rom_addr_q, ram_addr_q;
   logic [1:0]        lat_cnt_q;

   logic [N_SW-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
   logic [CNT_W-1:0]  cnt_q [N_SW];
   logic [CNT_W-1:0]  cnt_d [N_SW];
   logic [SW_SPAN-1:0] sw_view;
`ifdef SW_EDGE_EN
   logic [N_SW-1:0]   edge_q, edge_d, edge_clr_q;
`endif

   logic [ADDR_W-1:0] rom_off, ram_off, sw_off;
   region_t           req_region;
   logic              sw_bit;

   // Offsets wrap for addresses below a base, so one unsigned compare bounds each region.
   always_comb begin
      rom_off = bus.addr - ROM_LO;
      ram_off = bus.addr - RAM_LO;
      sw_off  = bus.addr - SW_LO;
      if (rom_off < ROM_SZ)      req_region = REG_ROM;
      else if (ram_off < RAM_SZ) req_region = REG_RAM;
      else if (sw_off < SW_SZ)   req_region = REG_SW;
      else                       req_region = REG_NONE;
   end

   assign sw_bit = |(sw_view & (SW_SPAN'(1) << sw_off));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_q        <= '0;
         rom_sel_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_vf_q    <= 1'b0;
         ram_wd_q    <= '0;
         rom_addr_q  <= '0;
         ram_addr_q  <= '0;
         lat_cnt_q   <= '0;
`ifdef SW_EDGE_EN
         edge_clr_q  <= '0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         ram_we_q    <= 1'b0;
`ifdef SW_EDGE_EN
         edge_clr_q  <= '0;
`endif
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (bus.req_valid && ready_q) begin
                  ready_q   <= 1'b0;
                  rd_q      <= '0;
                  rsp_err_q <= 1'b0;
                  lat_cnt_q <= 2'(MEM_LAT - 1);
                  state_q   <= RESP;
                  rsp_valid_q <= 1'b1;
                  case (req_region)
                     REG_ROM: begin
                        if (bus.we) rsp_err_q <= 1'b1;
                        else begin
                           rom_addr_q  <= rom_off;
                           rom_sel_q   <= 1'b1;
                           state_q     <= MEM_WAIT;
                           rsp_valid_q <= 1'b0;
                        end
                     end
                     REG_RAM: begin
                        ram_addr_q <= ram_off;
                        if (bus.we) begin
                           ram_we_q <= 1'b1;
                           ram_wd_q <= bus.wd;
                           ram_vf_q <= bus.vf;
                        end else begin
                           rom_sel_q   <= 1'b0;
                           state_q     <= MEM_WAIT;
                           rsp_valid_q <= 1'b0;
                        end
                     end
                     REG_SW: begin
                        if (bus.we) rsp_err_q <= 1'b1;
                        else begin
                           rd_q <= DATA_W'(sw_bit);
`ifdef SW_EDGE_EN
                           if (sw_off >= ADDR_W'(N_SW))
                              edge_clr_q <= N_SW'(1) << (sw_off - ADDR_W'(N_SW));
`endif
                        end
                     end
                     default: rsp_err_q <= 1'b1;
                  endcase
               end
            end
            MEM_WAIT: begin
               if (lat_cnt_q == 2'd0) begin
                  rd_q        <= rom_sel_q ? rom_rd : ram_rd;
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 2'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A channel's stable value flips only after DEB_CYCLES consecutive differing synced samples.
   always_comb begin
      sync1_d  = sw_in;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      for (int i = 0; i < N_SW; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < N_SW; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         for (int i = 0; i < N_SW; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef SW_EDGE_EN
   // A rising edge arriving in the clearing cycle keeps the flag set.
   always_comb edge_d = (edge_q & ~edge_clr_q) | (stable_d & ~stable_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) edge_q <= '0;
      else     edge_q <= edge_d;
   end

   assign sw_view = {edge_q, stable_q};
`else
   assign sw_view = stable_q;
`endif

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rd        = rd_q;
   assign bus.rsp_err   = rsp_err_q;
   assign rom_addr      = rom_addr_q;
   assign ram_we        = ram_we_q;
   assign ram_vf        = ram_vf_q;
   assign ram_addr      = ram_addr_q;
   assign ram_wd        = ram_wd_q;
   assign dbg_state     = state_q;
endmodule
